// File: rtl/mem_stage_pipe.sv
// MIPS MEM stage: byte-addressed data memory with configurable load latency plus the MEM/WB register.
// Optional performance counters are compiled in when MEM_PERF_EN is defined.
module mem_stage_pipe #(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 0,
  parameter int REG_W   = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             EX_Valid,
  input  logic             EX_RegWrite,
  input  logic             EX_MemToReg,
  input  logic             EX_MemRead,
  input  logic             EX_MemWrite,
  input  logic [1:0]       EX_Size,
  input  logic             EX_Unsigned,
  input  logic [31:0]      EX_ALUResult,
  input  logic [31:0]      EX_WriteData,
  input  logic [REG_W-1:0] EX_WriteReg,
  output logic             MEM_Stall,
  output logic             WB_Valid,
  output logic [1:0]       WB_OUT,
  output logic [31:0]      READ_DATA_OUT,
  output logic [31:0]      ALU_RESULT_OUT,
  output logic [REG_W-1:0] WRITE_REG_OUT,
  output logic             Misaligned
`ifdef MEM_PERF_EN
  ,
  output logic [31:0]      Load_Count,
  output logic [31:0]      Store_Count,
  output logic [31:0]      Stall_Count
`endif
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam bit         LAT_ON  = (MEM_LAT != 0);
  localparam bit         LAT_ONE = (MEM_LAT == 1);
  localparam logic [3:0] LAT_M1  = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nxt_s;
  logic [31:0]         mem_r [DEPTH];

  logic [ADDR_W-1:0]   widx_s;
  logic [1:0]          lane_s;
  logic                misalign_s;
  logic                store_s;
  logic                load_s;
  logic                stall_s;
  logic                accept_s;
  logic [31:0]         rd_word_s;
  logic [31:0]         wdata_s;
  logic [3:0]          be_s;
  logic                unused_addr_s;

  // Extracts the addressed byte/halfword and sign- or zero-extends it.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: load_ext = word;
    endcase
  endfunction

  // Byte enables for a store of the given size at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicates narrow store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  assign widx_s        = EX_ALUResult[ADDR_W+1:2];
  assign lane_s        = EX_ALUResult[1:0];
  assign unused_addr_s = ^EX_ALUResult[31:ADDR_W+2];

  // Access classification; size 11 behaves as a word access.
  always_comb begin
    misalign_s = EX_Valid & (EX_MemRead | EX_MemWrite) &
                 (((EX_Size == 2'b01) & lane_s[0]) | (EX_Size[1] & (lane_s != 2'b00)));
    store_s    = EX_Valid & EX_MemWrite & ~misalign_s;
    load_s     = EX_Valid & EX_MemRead & ~EX_MemWrite & ~misalign_s;
    rd_word_s  = mem_r[widx_s];
    wdata_s    = store_data(EX_Size, EX_WriteData);
    be_s       = byte_en(EX_Size, lane_s);
  end

  // Load-latency FSM: IDLE stalls one cycle, WAIT covers the remaining N-1, DONE accepts.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_s && LAT_ON) begin
          stall_s     = 1'b1;
          cnt_nxt_s   = LAT_M1;
          state_nxt_s = LAT_ONE ? DONE : WAIT;
        end else begin
          accept_s    = 1'b1;
        end
      end
      WAIT: begin
        stall_s   = 1'b1;
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        accept_s    = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  assign MEM_Stall = stall_s;

  // FSM state, latency counter and MEM/WB register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      WB_Valid       <= 1'b0;
      WB_OUT         <= 2'b00;
      READ_DATA_OUT  <= 32'd0;
      ALU_RESULT_OUT <= 32'd0;
      WRITE_REG_OUT  <= '0;
      Misaligned     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        WB_Valid       <= EX_Valid;
        WB_OUT         <= EX_Valid ? {EX_RegWrite & ~misalign_s, EX_MemToReg} : 2'b00;
        READ_DATA_OUT  <= load_s ? load_ext(rd_word_s, lane_s, EX_Size, EX_Unsigned) : 32'd0;
        ALU_RESULT_OUT <= EX_ALUResult;
        WRITE_REG_OUT  <= EX_WriteReg;
        Misaligned     <= misalign_s;
      end else begin
        WB_Valid       <= 1'b0;
        WB_OUT         <= 2'b00;
        READ_DATA_OUT  <= 32'd0;
        ALU_RESULT_OUT <= 32'd0;
        WRITE_REG_OUT  <= '0;
        Misaligned     <= 1'b0;
      end
    end
  end

  // Data array: byte-lane writes, contents deliberately not reset.
  always_ff @(posedge Clk) begin
    if (Rst_n && accept_s && store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[widx_s][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

`ifdef MEM_PERF_EN
  // Free-running wrap-around activity counters.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Load_Count  <= 32'd0;
      Store_Count <= 32'd0;
      Stall_Count <= 32'd0;
    end else begin
      if (accept_s && load_s) begin
        Load_Count <= Load_Count + 32'd1;
      end
      if (accept_s && store_s) begin
        Store_Count <= Store_Count + 32'd1;
      end
      if (stall_s) begin
        Stall_Count <= Stall_Count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed scoreboard bench for mem_stage_pipe: three instances (latency 0, latency 3 with
// a 16-word memory, latency 4) share one stimulus bus; sel picks which one is observed.
module tb_mem_stage_pipe;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        EX_Valid, EX_RegWrite, EX_MemToReg, EX_MemRead, EX_MemWrite, EX_Unsigned;
  logic [1:0]  EX_Size;
  logic [31:0] EX_ALUResult, EX_WriteData;
  logic [4:0]  EX_WriteReg;

  logic        a_stall, a_valid, a_mis, b_stall, b_valid, b_mis, c_stall, c_valid, c_mis;
  logic [1:0]  a_wbout, b_wbout, c_wbout;
  logic [31:0] a_rd, a_alu, b_rd, b_alu, c_rd, c_alu;
  logic [4:0]  a_wreg, b_wreg, c_wreg;

  logic        obs_stall, obs_valid, obs_mis;
  logic [1:0]  obs_wbout;
  logic [31:0] obs_rd, obs_alu;
  logic [4:0]  obs_wreg;
  int          sel = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic [1:0]  wbout;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        mis;
    int          stalls;
  } exp_t;
  exp_t sb_q[$];

  always #5 Clk = ~Clk;

  mem_stage_pipe #(.ADDR_W(10), .MEM_LAT(0), .REG_W(5)) u_a (
    .Clk(Clk), .Rst_n(Rst_n), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemToReg(EX_MemToReg), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_Size(EX_Size), .EX_Unsigned(EX_Unsigned), .EX_ALUResult(EX_ALUResult),
    .EX_WriteData(EX_WriteData), .EX_WriteReg(EX_WriteReg), .MEM_Stall(a_stall),
    .WB_Valid(a_valid), .WB_OUT(a_wbout), .READ_DATA_OUT(a_rd), .ALU_RESULT_OUT(a_alu),
    .WRITE_REG_OUT(a_wreg), .Misaligned(a_mis));

  mem_stage_pipe #(.ADDR_W(4), .MEM_LAT(3), .REG_W(5)) u_b (
    .Clk(Clk), .Rst_n(Rst_n), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemToReg(EX_MemToReg), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_Size(EX_Size), .EX_Unsigned(EX_Unsigned), .EX_ALUResult(EX_ALUResult),
    .EX_WriteData(EX_WriteData), .EX_WriteReg(EX_WriteReg), .MEM_Stall(b_stall),
    .WB_Valid(b_valid), .WB_OUT(b_wbout), .READ_DATA_OUT(b_rd), .ALU_RESULT_OUT(b_alu),
    .WRITE_REG_OUT(b_wreg), .Misaligned(b_mis));

  mem_stage_pipe #(.ADDR_W(10), .MEM_LAT(4), .REG_W(5)) u_c (
    .Clk(Clk), .Rst_n(Rst_n), .EX_Valid(EX_Valid), .EX_RegWrite(EX_RegWrite),
    .EX_MemToReg(EX_MemToReg), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
    .EX_Size(EX_Size), .EX_Unsigned(EX_Unsigned), .EX_ALUResult(EX_ALUResult),
    .EX_WriteData(EX_WriteData), .EX_WriteReg(EX_WriteReg), .MEM_Stall(c_stall),
    .WB_Valid(c_valid), .WB_OUT(c_wbout), .READ_DATA_OUT(c_rd), .ALU_RESULT_OUT(c_alu),
    .WRITE_REG_OUT(c_wreg), .Misaligned(c_mis));

  always_comb begin
    obs_stall = a_stall; obs_valid = a_valid; obs_mis = a_mis; obs_wbout = a_wbout;
    obs_rd = a_rd; obs_alu = a_alu; obs_wreg = a_wreg;
    case (sel)
      1: begin
        obs_stall = b_stall; obs_valid = b_valid; obs_mis = b_mis; obs_wbout = b_wbout;
        obs_rd = b_rd; obs_alu = b_alu; obs_wreg = b_wreg;
      end
      2: begin
        obs_stall = c_stall; obs_valid = c_valid; obs_mis = c_mis; obs_wbout = c_wbout;
        obs_rd = c_rd; obs_alu = c_alu; obs_wreg = c_wreg;
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    EX_Valid = 1'b0; EX_RegWrite = 1'b0; EX_MemToReg = 1'b0; EX_MemRead = 1'b0;
    EX_MemWrite = 1'b0; EX_Size = 2'b10; EX_Unsigned = 1'b0; EX_ALUResult = 32'd0;
    EX_WriteData = 32'd0; EX_WriteReg = 5'd0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "/valid"}, {31'd0, obs_valid}, 32'd0);
    chk({tag, "/wbout"}, {30'd0, obs_wbout}, 32'd0);
    chk({tag, "/rd"}, obs_rd, 32'd0);
    chk({tag, "/alu"}, obs_alu, 32'd0);
    chk({tag, "/wreg"}, {27'd0, obs_wreg}, 32'd0);
    chk({tag, "/mis"}, {31'd0, obs_mis}, 32'd0);
    chk({tag, "/stall"}, {31'd0, obs_stall}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_zero(tag);
    Rst_n = 1'b1;
  endtask

  // Drive one instruction, push its expected MEM/WB entry, count stalls, pop and compare.
  task automatic issue(input string tag, input logic rw, input logic m2r, input logic mr,
                       input logic mw, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg,
                       input logic [31:0] exp_rd, input logic exp_mis, input int exp_stalls);
    exp_t e;
    int   stalls;
    bit   got;
    e.rd = exp_rd; e.wbout = {rw & ~exp_mis, m2r}; e.alu = addr; e.wreg = wreg;
    e.mis = exp_mis; e.stalls = exp_stalls;
    sb_q.push_back(e);
    EX_Valid = 1'b1; EX_RegWrite = rw; EX_MemToReg = m2r; EX_MemRead = mr; EX_MemWrite = mw;
    EX_Size = sz; EX_Unsigned = uns; EX_ALUResult = addr; EX_WriteData = wd; EX_WriteReg = wreg;
    stalls = 0;
    got = 1'b0;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (obs_stall) stalls++;
      @(posedge Clk);
      #1;
      if (obs_valid) begin
        got = 1'b1;
        break;
      end
    end
    idle_inputs();
    e = sb_q.pop_front();
    if (!got) begin
      chk({tag, "/timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "/rd"}, obs_rd, e.rd);
      chk({tag, "/wbout"}, {30'd0, obs_wbout}, {30'd0, e.wbout});
      chk({tag, "/alu"}, obs_alu, e.alu);
      chk({tag, "/wreg"}, {27'd0, obs_wreg}, {27'd0, e.wreg});
      chk({tag, "/mis"}, {31'd0, obs_mis}, {31'd0, e.mis});
      chk({tag, "/stalls"}, stalls, e.stalls);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_n = 1'b0;
    idle_inputs();
    // Latency-0 instance: sizes, extension, alignment, pass-through.
    sel = 0;
    do_reset("rst_a");
    issue("sw00",   1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0000, 32'h1122_3344, 5'd0, 32'd0, 1'b0, 0);
    issue("sw10",   1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 0);
    issue("lw10",   1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 5'd3, 32'hDEAD_BEEF, 1'b0, 0);
    issue("sb13",   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_5680, 5'd0, 32'd0, 1'b0, 0);
    issue("lb13",   1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0, 5'd4, 32'hFFFF_FF80, 1'b0, 0);
    issue("lbu13",  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'd0, 5'd5, 32'h0000_0080, 1'b0, 0);
    issue("lw10b",  1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 5'd6, 32'h80AD_BEEF, 1'b0, 0);
    issue("lh10",   1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'd0, 5'd7, 32'hFFFF_BEEF, 1'b0, 0);
    issue("lhu12",  1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'd0, 5'd8, 32'h0000_80AD, 1'b0, 0);
    issue("lb10",   1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'd0, 5'd9, 32'hFFFF_FFEF, 1'b0, 0);
    issue("lw02mis",1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'd0, 5'd10, 32'd0, 1'b1, 0);
    issue("sh11mis",1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_FFFF, 5'd0, 32'd0, 1'b1, 0);
    issue("lw00",   1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 5'd11, 32'h1122_3344, 1'b0, 0);
    issue("lw10c",  1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 5'd12, 32'h80AD_BEEF, 1'b0, 0);
    issue("aluop",  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'd0, 5'd13, 32'd0, 1'b0, 0);
    issue("rdwr20", 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 5'd0, 32'd0, 1'b0, 0);
    issue("lw20",   1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'd0, 5'd14, 32'hCAFE_F00D, 1'b0, 0);
    issue("lsz3_20",1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'd0, 5'd15, 32'hCAFE_F00D, 1'b0, 0);
    // Invalid slot must become a bubble even with control bits set.
    EX_Valid = 1'b0; EX_RegWrite = 1'b1; EX_MemToReg = 1'b1; EX_MemRead = 1'b1;
    @(posedge Clk);
    #1;
    chk("bubble/valid", {31'd0, obs_valid}, 32'd0);
    chk("bubble/wbout", {30'd0, obs_wbout}, 32'd0);
    idle_inputs();

    // Latency-3 instance with 16-word memory: stall length and address wrap.
    sel = 1;
    do_reset("rst_b");
    issue("b_sh12", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_8001, 5'd0, 32'd0, 1'b0, 0);
    issue("b_lh12", 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'd0, 5'd2, 32'hFFFF_8001, 1'b0, 3);
    issue("b_sw40", 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0000_1234, 5'd0, 32'd0, 1'b0, 0);
    issue("b_lw00", 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'd0, 5'd3, 32'h0000_1234, 1'b0, 3);

    // Latency-4 instance: reset in the second stall cycle abandons the load.
    sel = 2;
    do_reset("rst_c");
    EX_Valid = 1'b1; EX_RegWrite = 1'b1; EX_MemToReg = 1'b1; EX_MemRead = 1'b1;
    EX_Size = 2'b10; EX_ALUResult = 32'h0000_0008; EX_WriteReg = 5'd21;
    #1;
    chk("c_stall1", {31'd0, obs_stall}, 32'd1);
    @(posedge Clk);
    #1;
    chk("c_stall2", {31'd0, obs_stall}, 32'd1);
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    idle_inputs();
    #1;
    check_zero("c_abandon");
    issue("c_alu",  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'hA5A5_0001, 32'd0, 5'd9, 32'd0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
Name: mem_stage_pipe

Overview:
Parametrised MIPS MEM stage: byte-addressed data memory plus the MEM/WB pipeline register.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Read latency is configurable; the stage stalls the upstream pipeline while a load is outstanding.
- Sits between the EX/MEM register and the WB mux, and replaces the fixed single-cycle MEM integration block.

Parameters:
ADDR_W, 10, word-address width; memory depth = 2^ADDR_W words of 32 bits.
MEM_LAT, 0, extra load-latency cycles (0..15); 0 means the load completes in the accept cycle.
REG_W, 5, destination register index width.

Ports:
Clk  in  1  clock, all state updates on rising edge.
Rst_n  in  1  synchronous active-low reset.
EX_Valid  in  1  EX/MEM holds a valid instruction this cycle.
EX_RegWrite  in  1  instruction writes the register file.
EX_MemToReg  in  1  WB selects read data (1) or ALU result (0).
EX_MemRead  in  1  load.
EX_MemWrite  in  1  store.
EX_Size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
EX_Unsigned  in  1  zero-extend loads (LBU/LHU).
EX_ALUResult  in  32  byte address for memory ops; pass-through value otherwise.
EX_WriteData  in  32  store data; low bytes are used for SB/SH.
EX_WriteReg  in  REG_W  destination register.
MEM_Stall  out  1  upstream must hold EX_* stable and not advance.
WB_Valid  out  1  MEM/WB holds a valid instruction.
WB_OUT  out  2  {RegWrite, MemToReg} registered.
READ_DATA_OUT  out  32  extended load data.
ALU_RESULT_OUT  out  32  registered EX_ALUResult.
WRITE_REG_OUT  out  REG_W  registered EX_WriteReg.
Misaligned  out  1  one-cycle registered flag for an access suppressed because of misalignment.

Behaviour:
Reset:
- Rst_n=0 at a rising edge: all outputs 0, FSM to IDLE, latency counter 0.
- Memory array contents are NOT reset.

Addressing:
- Word index = EX_ALUResult[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo depth.
- Byte lane = EX_ALUResult[1:0], little-endian: lane 0 = bits 7:0.

Alignment:
- Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
- Misaligned access: no memory write, no stall, Misaligned=1 next cycle, WB_Valid=1 with WB_OUT[1] forced 0.

Stores:
- Single cycle, never stall; byte enables written at the edge.
- SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}.
- Store MEM/WB entry has WB_OUT as supplied (normally 00).

Loads, MEM_LAT=0:
- Combinational read; extended data registered into READ_DATA_OUT at the accept edge.
- Result is valid the next cycle and MEM_Stall is never asserted.

Loads, MEM_LAT=N>0. FSM has states IDLE, WAIT and DONE:
- IDLE: an aligned valid load asserts MEM_Stall combinationally, loads counter=N-1 and moves to WAIT. WB_Valid=0 is written, i.e. a bubble.
- WAIT: MEM_Stall=1 and bubbles continue. The counter decrements each cycle; at 0 the FSM moves to DONE.
- DONE: MEM_Stall=0; the load's MEM/WB entry is registered at this edge, then IDLE.
- Total stall is exactly N cycles; the entry appears N+1 cycles after first presentation.

Load extension:
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- LW returns the word; for non-load entries READ_DATA_OUT is 0.

Other cases:
- EX_Valid=0: bubble entry, i.e. WB_Valid=0 and WB_OUT=00; no memory access.
- MemRead and MemWrite both set: treated as a store, and READ_DATA_OUT=0.
- Store immediately followed by a load to the same word returns the new data, because the write completes before the read cycle.
- Reset during WAIT: load abandoned, FSM to IDLE, no MEM/WB entry produced.
- EX_* changing while MEM_Stall=1 is a protocol violation; the inputs are sampled only in DONE (or at accept when N=0).

Optional Feature:
MEM_PERF_EN:
- Defined: adds outputs Load_Count, Store_Count and Stall_Count, each 32-bit.
  - Load_Count and Store_Count increment on each completed aligned load/store.
  - Stall_Count increments on each cycle with MEM_Stall=1.
  - All three wrap at 2^32 and are cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, then LW addr 0x10 (MEM_LAT=0) -> next cycle READ_DATA_OUT=0xDEADBEEF, WB_OUT as supplied, MEM_Stall never 1.
- SB 0x80 to addr 0x13, then LB and LBU addr 0x13 -> 0xFFFFFF80 and 0x00000080; other lanes of the word unchanged.
- MEM_LAT=3, LH addr 0x12 holding 0x8001 -> MEM_Stall high exactly 3 cycles, WB_Valid=0 during them, then READ_DATA_OUT=0xFFFF8001 with WB_Valid=1.
- LW addr 0x02 with EX_RegWrite=1 -> Misaligned=1 for one cycle, WB_OUT[1]=0, memory unchanged, no stall.
- MEM_LAT=4, Rst_n=0 in the second stall cycle -> all outputs 0 next cycle, FSM IDLE; the following ALU-op entry passes ALU_RESULT_OUT unchanged.
- ADDR_W=4: SW 0x1234 to addr 0x40, then LW addr 0x00 -> 0x00001234 (wrap-around).
